store_unit: RTL
===============

Name: store_unit

Overview:
Memory write path for the multicycle CPU. It is the store-side counterpart of the load-side byte/halfword extraction. It accepts one store request (sw/sh/sb) from the control unit and produces the memory write. Byte and halfword stores use a read-modify-write of the containing word, because the single-port memory is word-wide. Word stores skip the read. The unit sits between the control unit / register B / ALUOut and the memory's address, write-enable and data-in pins.

Parameters:
READ_LATENCY, 1, cycles from mem_addr stable to mem_rdata valid; legal range 1..7.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  store request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_addr  in  32  byte address (ALUOut)
req_data  in  32  store data (register B); low byte/half used for sb/sh
req_size  in  2  00=word, 01=half, 10=byte, 11=reserved (treated as word)
mem_addr  out  32  word-aligned memory address
mem_wr  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the store completes
misalign  out  1  misaligned request flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, async): state=IDLE; all internal registers cleared; mem_wr=0, mem_addr=0, mem_wdata=0, done=0, busy=0, misalign=0, req_ready=1. Takes effect mid-operation immediately; mem_wr drops without waiting for a clock edge. No partial write completes after reset.
- Handshake: a request is accepted on the rising edge where req_valid=1 and req_ready=1. On acceptance, addr, data and size are registered. Request inputs are ignored at all other times.
- mem_addr = {addr_q[31:2],2'b00} in READ and WRITE; 0 in IDLE and DONE.
- Byte lanes are big-endian (MIPS):
  - Byte: offset 0 maps to bits 31:24, 1 to 23:16, 2 to 15:8, 3 to 7:0.
  - Half: addr[1]=0 maps to bits 31:16; addr[1]=1 maps to bits 15:0.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: on accept, go to WRITE if size is word/reserved, else go to READ.
  - READ: mem_wr=0; stays READ_LATENCY+1 cycles (3-bit counter). On the final READ edge, capture mem_rdata into merge_q with the selected lane replaced by req_data[7:0] or [15:0]. Then go to WRITE.
  - WRITE: exactly one cycle with mem_wr=1. mem_wdata = data_q for word stores; merge_q for sh/sb. Go to DONE.
  - DONE: done=1 for one cycle; go to IDLE. req_ready returns high the following cycle.
- Latency from accept edge to done high:
  - word: 2 cycles.
  - half/byte: READ_LATENCY+3 cycles.
- Back-to-back: req_valid held high is accepted again on the first IDLE edge; minimum spacing is word 3 cycles, sub-word READ_LATENCY+4.
- mem_wdata is 0 outside WRITE.
- Without the optional feature, misaligned low address bits are ignored: word ignores addr[1:0]; half ignores addr[0].

Optional Feature:
STORE_ALIGN_CHECK_EN:
- Defined: a word request with addr[1:0]!=0, or a half request with addr[0]=1, is accepted and goes IDLE->DONE directly. No READ, no mem_wr. misalign=1 in the same cycle as done, and the memory is untouched.
- Undefined: misalign tied 0; alignment as described in Behaviour.

Test Plan:
1. sw: addr=0x0000_0104, data=0xDEADBEEF, size=00. Required: one mem_wr cycle with mem_addr=0x104, mem_wdata=0xDEADBEEF; done 2 cycles after accept; no read cycles.
2. sb sweep: mem word at 0x20=0x11223344, data=0xAA, offsets 0..3. Required writes: 0xAA223344, 0x11AA3344, 0x1122AA44, 0x112233AA; done at READ_LATENCY+3 cycles after accept.
3. sh: word 0x11223344, data=0xCAFEBABE. addr 0x22 gives write 0x1122BABE; addr 0x20 gives 0xBABE3344.
4. Back-to-back: req_valid held high with an sw then an sb. req_ready is low while busy; the second request is accepted exactly one cycle after the first done; both writes are correct and nothing is dropped.
5. Reset mid-op: assert reset during the WRITE cycle of an sb. Required: mem_wr falls asynchronously and busy=0, done=0. After release req_ready=1 and no further write occurs.
6. With STORE_ALIGN_CHECK_EN: sw at 0x102 and sh at 0x21. Required: done and misalign both high together, mem_wr never asserted. With the feature undefined, sw at 0x102 writes at mem_addr 0x100.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: memory write path for sw/sh/sb.
// Sub-word stores read the containing word, merge the new lane and write the word back.
// Optional build macro: STORE_ALIGN_CHECK_EN (misaligned word/half requests finish without touching memory).
module store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        misalign
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY);
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      size_q, size_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   merge_q, merge_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   mem_wdata_d;
    logic            accept_c;
    logic            fault_c;

    assign accept_c = req_valid && req_ready;

`ifdef STORE_ALIGN_CHECK_EN
    // Word requests need addr[1:0]==0, half requests need addr[0]==0.
    assign fault_c = (req_size == SZ_HALF) ? req_addr[0] :
                     (req_size == SZ_BYTE) ? 1'b0 : (|req_addr[1:0]);

    // misalign pulses together with done for a rejected request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (state_q == IDLE) && accept_c && fault_c;
        end
    end
`else
    assign fault_c  = 1'b0;
    assign misalign = 1'b0;
`endif

    // State and datapath registers; outputs are registered from next-state values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
            merge_q   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            merge_q   <= merge_d;
            req_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            mem_wr    <= (state_d == WRITE);
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Next-state, request capture, lane merge and next output values.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        merge_d = merge_q;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    size_d = req_size;
                    cnt_d  = '0;
                    if (fault_c) begin
                        state_d = DONE;
                    end else if (req_size == SZ_HALF || req_size == SZ_BYTE) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = WRITE;
                    merge_d = mem_rdata;
                    if (size_q == SZ_HALF) begin
                        if (addr_q[1]) begin
                            merge_d[15:0] = data_q[15:0];
                        end else begin
                            merge_d[31:16] = data_q[15:0];
                        end
                    end else begin
                        unique case (addr_q[1:0])
                            2'b00: merge_d[31:24] = data_q[7:0];
                            2'b01: merge_d[23:16] = data_q[7:0];
                            2'b10: merge_d[15:8]  = data_q[7:0];
                            2'b11: merge_d[7:0]   = data_q[7:0];
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: state_d = DONE;
            DONE:  state_d = IDLE;
        endcase

        mem_addr_d  = (state_d == READ || state_d == WRITE) ? {addr_d[AW-1:2], 2'b00} : '0;
        mem_wdata_d = '0;
        if (state_d == WRITE) begin
            mem_wdata_d = (size_d == SZ_HALF || size_d == SZ_BYTE) ? merge_d : data_d;
        end
    end
endmodule
